// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the two-level cache refill path: the cache address
// width, the default memory timeout and the refill controller state encoding.
// Imported by the refill controller, its memory interface and the bench.
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int ADDR_W          = 11;
    localparam int MEM_TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        PROMOTE,
        MEM_WAIT,
        FILL_L2,
        FILL_L1
    } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl_if
// Read request/acknowledge handshake between the refill controller and main
// memory.
//   mem_req  : read request, held high until acknowledged or abandoned
//   mem_addr : address of the outstanding request
//   mem_ack  : one-cycle data-ready pulse from memory
// Modports: master (controller side), slave (memory side).
// ---------------------------------------------------------------------------
interface cache_refill_ctrl_if
    import cache_pkg::*;
#(
    parameter int AW = cache_pkg::ADDR_W
);

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack
    );

endinterface

// File: rtl/cache_refill_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for refill statistics. Sticks at all-ones.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the count)
//   inc_i      : increment request for this cycle
//   clear_i    : synchronous clear, takes priority over inc_i
//   count_o    : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
// Services the result of each L1/L2 lookup: an L2 hit promotes the line into
// L1, a full miss fetches the line from memory, then fills L2 and then L1.
// Optional statistics counters are built when CACHE_REFILL_STATS_EN is defined.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   addr_i           : lookup address (one cycle ahead of the result flags)
//   l1_hit_i         : L1 hit pulse (no action needed)
//   l2_hit_i, miss_i : L2 hit / full miss pulses
//   mem_if           : memory request/acknowledge handshake (master side)
//   l2_fill_valid_o/l2_fill_addr_o : one-cycle L2 fill strobe and address
//   l1_fill_valid_o/l1_fill_addr_o : one-cycle L1 fill strobe and address
//   busy_o           : a promotion or refill is in flight
//   err_o            : one-cycle pulse when memory fails to answer in time
//   promote_cnt_o, miss_cnt_o, drop_cnt_o, timeout_cnt_o : statistics
//                      (CACHE_REFILL_STATS_EN only)
// ---------------------------------------------------------------------------
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W      = cache_pkg::ADDR_W,
    parameter int MEM_TIMEOUT = cache_pkg::MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                l1_hit_i,
    input  logic                l2_hit_i,
    input  logic                miss_i,
    cache_refill_ctrl_if.master mem_if,
    output logic                l2_fill_valid_o,
    output logic [ADDR_W-1:0]   l2_fill_addr_o,
    output logic                l1_fill_valid_o,
    output logic [ADDR_W-1:0]   l1_fill_addr_o,
    output logic                busy_o,
`ifdef CACHE_REFILL_STATS_EN
    output logic [CNT_W-1:0]    promote_cnt_o,
    output logic [CNT_W-1:0]    miss_cnt_o,
    output logic [CNT_W-1:0]    drop_cnt_o,
    output logic [CNT_W-1:0]    timeout_cnt_o,
`endif
    output logic                err_o
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    refill_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_dly_q;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              l2_fv_q, l2_fv_d;
    logic [ADDR_W-1:0] l2_fa_q, l2_fa_d;
    logic              l1_fv_q, l1_fv_d;
    logic [ADDR_W-1:0] l1_fa_q, l1_fa_d;
    logic              err_q, err_d;

    // The result flags lag the address by one cycle, so the address is
    // delayed to line up with the flags that describe it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_dly_q <= '0;
            req_addr_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            timer_q    <= '0;
            l2_fv_q    <= 1'b0;
            l2_fa_q    <= '0;
            l1_fv_q    <= 1'b0;
            l1_fa_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_dly_q <= addr_i;
            req_addr_q <= req_addr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            timer_q    <= timer_d;
            l2_fv_q    <= l2_fv_d;
            l2_fa_q    <= l2_fa_d;
            l1_fv_q    <= l1_fv_d;
            l1_fa_q    <= l1_fa_d;
            err_q      <= err_d;
        end
    end

    // Strobes and err default low so each is exactly one cycle wide. An L1
    // hit masks any simultaneous L2 hit or miss. In MEM_WAIT the ack is
    // tested before the timeout so a last-cycle ack still completes.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        timer_d    = timer_q;
        l2_fv_d    = 1'b0;
        l2_fa_d    = l2_fa_q;
        l1_fv_d    = 1'b0;
        l1_fa_d    = l1_fa_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!l1_hit_i && l2_hit_i) begin
                    req_addr_d = addr_dly_q;
                    state_d    = PROMOTE;
                end else if (!l1_hit_i && miss_i) begin
                    req_addr_d = addr_dly_q;
                    mem_addr_d = addr_dly_q;
                    mem_req_d  = 1'b1;
                    timer_d    = '0;
                    state_d    = MEM_WAIT;
                end
            end
            PROMOTE: begin
                l1_fv_d = 1'b1;
                l1_fa_d = req_addr_q;
                state_d = FILL_L1;
            end
            MEM_WAIT: begin
                if (mem_if.mem_ack) begin
                    mem_req_d = 1'b0;
                    l2_fv_d   = 1'b1;
                    l2_fa_d   = req_addr_q;
                    state_d   = FILL_L2;
                end else if (timer_q == TW'(MEM_TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            FILL_L2: begin
                l1_fv_d = 1'b1;
                l1_fa_d = req_addr_q;
                state_d = FILL_L1;
            end
            FILL_L1: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_if.mem_req  = mem_req_q;
    assign mem_if.mem_addr = mem_addr_q;
    assign l2_fill_valid_o = l2_fv_q;
    assign l2_fill_addr_o  = l2_fa_q;
    assign l1_fill_valid_o = l1_fv_q;
    assign l1_fill_addr_o  = l1_fa_q;
    assign busy_o          = (state_q != IDLE);
    assign err_o           = err_q;

`ifdef CACHE_REFILL_STATS_EN
    logic promote_inc, miss_inc, drop_inc, timeout_inc;

    // Acceptance mirrors the IDLE decode; anything other than an L1 hit
    // arriving while not idle is a dropped request.
    always_comb begin
        promote_inc = 1'b0;
        miss_inc    = 1'b0;
        drop_inc    = 1'b0;
        timeout_inc = err_d;
        if (state_q == IDLE) begin
            promote_inc = !l1_hit_i && l2_hit_i;
            miss_inc    = !l1_hit_i && !l2_hit_i && miss_i;
        end else begin
            drop_inc    = !l1_hit_i && (l2_hit_i || miss_i);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_promote_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(promote_inc), .clear_i(1'b0), .count_o(promote_cnt_o)
    );
    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(miss_inc), .clear_i(1'b0), .count_o(miss_cnt_o)
    );
    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(drop_inc), .clear_i(1'b0), .count_o(drop_cnt_o)
    );
    sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(timeout_inc), .clear_i(1'b0), .count_o(timeout_cnt_o)
    );
`endif

endmodule
